// File: rtl/im_compression_ctrl.sv
// Frame scheduler: walks output tiles row-major, issues one engine job per tile.
// Optional engine-done watchdog enabled by defining IM_COMPRESSION_CTRL_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for iframe_ready, counters cleared
// ISSUE   | start pulse for current tile unless ihold
// WAIT    | engine running, waiting for iwork_done
// ADVANCE | step tile counters and pointers
// DONE    | frame complete pulse
module im_compression_ctrl #(
  parameter int pIN_IM_WIDTH   = 640,
  parameter int pIN_IM_HEIGHT  = 480,
  parameter int pOUT_IM_WIDTH  = 160,
  parameter int pOUT_IM_HEIGHT = 120,
  parameter int pAREA_WIDTH    = 4,
  parameter int pAREA_HEIGHT   = 4,
  parameter int pTIMEOUT       = 64
) (
  input  logic iclk,
  input  logic irst,
  input  logic iframe_ready,
  input  logic ihold,
  input  logic iwork_done,
  output logic ostart_work,
  output logic [$clog2(pIN_IM_WIDTH*pIN_IM_HEIGHT)-1:0]   odata_start_ptr,
  output logic [$clog2(pOUT_IM_WIDTH*pOUT_IM_HEIGHT)-1:0] owr_addr,
  output logic oframe_busy,
  output logic oframe_done,
  output logic oframe_overrun,
  output logic otimeout
);

  localparam int PTR_W  = $clog2(pIN_IM_WIDTH*pIN_IM_HEIGHT);
  localparam int ADDR_W = $clog2(pOUT_IM_WIDTH*pOUT_IM_HEIGHT);
  localparam int TX_W   = (pOUT_IM_WIDTH  > 1) ? $clog2(pOUT_IM_WIDTH)  : 1;
  localparam int TY_W   = (pOUT_IM_HEIGHT > 1) ? $clog2(pOUT_IM_HEIGHT) : 1;

  localparam logic [PTR_W-1:0] ROW_STEP = PTR_W'(pAREA_HEIGHT*pIN_IM_WIDTH);
  localparam logic [PTR_W-1:0] COL_STEP = PTR_W'(pAREA_WIDTH);
  localparam logic [TX_W-1:0]  TX_LAST  = TX_W'(pOUT_IM_WIDTH-1);
  localparam logic [TY_W-1:0]  TY_LAST  = TY_W'(pOUT_IM_HEIGHT-1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_ADVANCE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [TX_W-1:0]  tx;
  logic [TY_W-1:0]  ty;
  logic [PTR_W-1:0] row_base;
  logic             last_tile;
  logic             to_hit;

  assign last_tile = (tx == TX_LAST) && (ty == TY_LAST);

`ifdef IM_COMPRESSION_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(pTIMEOUT+1);
  logic [TO_W-1:0] wait_cnt;

  // Down-counter loaded as the job is issued; terminal count ends the wait.
  always_ff @(posedge iclk) begin
    if (!irst) begin
      wait_cnt <= '0;
    end else if ((state == ST_ISSUE) && !ihold) begin
      wait_cnt <= TO_W'(pTIMEOUT-1);
    end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  assign to_hit   = (state == ST_WAIT) && !iwork_done && (wait_cnt == '0);
  assign otimeout = to_hit;
`else
  assign to_hit   = 1'b0;
  assign otimeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (iframe_ready) state_nxt = ST_ISSUE;
      ST_ISSUE:   if (!ihold) state_nxt = ST_WAIT;
      ST_WAIT:    if (iwork_done || to_hit) state_nxt = ST_ADVANCE;
      ST_ADVANCE: state_nxt = last_tile ? ST_DONE : ST_ISSUE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (!irst) begin
      state           <= ST_IDLE;
      tx              <= '0;
      ty              <= '0;
      row_base        <= '0;
      odata_start_ptr <= '0;
      owr_addr        <= '0;
      oframe_overrun  <= 1'b0;
    end else begin
      state          <= state_nxt;
      oframe_overrun <= iframe_ready && (state != ST_IDLE);
      case (state)
        // Clearing in DONE means pointers already read 0 on the first IDLE cycle.
        ST_IDLE, ST_DONE: begin
          tx              <= '0;
          ty              <= '0;
          row_base        <= '0;
          odata_start_ptr <= '0;
          owr_addr        <= '0;
        end
        ST_ADVANCE: begin
          if (tx == TX_LAST) begin
            if (ty != TY_LAST) begin
              tx              <= '0;
              ty              <= ty + 1'b1;
              row_base        <= row_base + ROW_STEP;
              odata_start_ptr <= row_base + ROW_STEP;
              owr_addr        <= owr_addr + 1'b1;
            end
          end else begin
            tx              <= tx + 1'b1;
            odata_start_ptr <= odata_start_ptr + COL_STEP;
            owr_addr        <= owr_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ostart_work = (state == ST_ISSUE) && !ihold;
  assign oframe_busy = (state != ST_IDLE);
  assign oframe_done = (state == ST_DONE);

endmodule

// File: tb/tb_im_compression_ctrl.sv
// Scoreboard bench for im_compression_ctrl with a 16x8 input, 4x4 tiles, 4x2 output.
// Define IM_COMPRESSION_CTRL_TIMEOUT_EN for both files to exercise the watchdog.
module tb_im_compression_ctrl;

  localparam int TO_CYC = 8;

  logic       iclk = 1'b0;
  logic       irst = 1'b0;
  logic       iframe_ready = 1'b0;
  logic       ihold = 1'b0;
  logic       eng_done = 1'b0;
  logic       man_done = 1'b0;
  logic       iwork_done;
  logic       ostart_work;
  logic [6:0] odata_start_ptr;
  logic [2:0] owr_addr;
  logic       oframe_busy;
  logic       oframe_done;
  logic       oframe_overrun;
  logic       otimeout;

  assign iwork_done = eng_done | man_done;

  always #5 iclk = ~iclk;

  im_compression_ctrl #(
    .pIN_IM_WIDTH(16), .pIN_IM_HEIGHT(8), .pOUT_IM_WIDTH(4), .pOUT_IM_HEIGHT(2),
    .pAREA_WIDTH(4), .pAREA_HEIGHT(4), .pTIMEOUT(TO_CYC)
  ) dut (
    .iclk(iclk), .irst(irst), .iframe_ready(iframe_ready), .ihold(ihold),
    .iwork_done(iwork_done), .ostart_work(ostart_work),
    .odata_start_ptr(odata_start_ptr), .owr_addr(owr_addr),
    .oframe_busy(oframe_busy), .oframe_done(oframe_done),
    .oframe_overrun(oframe_overrun), .otimeout(otimeout)
  );

  // Hand-computed start pointers: row 0 at 0,4,8,12; row 1 at 4*16=64 onward.
  int exp_tab [8] = '{0, 4, 8, 12, 64, 68, 72, 76};

  // Written only by the stimulus process
  int exp_ptr [64];
  int exp_addr [64];
  int wr_idx = 0;
  int exp_done = 0;
  int exp_ovr = 0;
  int exp_to = 0;
  int req_n = 0;
  int req_kind = 0;
  int end_req = 0;
  int eng_en = 1;

  // Written only by the monitor
  int rd_idx = 0;
  int done_seen = 0;
  int ovr_seen = 0;
  int to_seen = 0;
  int req_ack = 0;
  int since_start = 0;
  int checks = 0;
  int errors = 0;
  logic ovr_pend = 1'b0;

  // Engine model: done pulse sampled 6 edges after the start cycle.
  initial begin
    forever begin
      @(negedge iclk);
      if (eng_en != 0 && ostart_work) begin
        repeat (5) @(posedge iclk);
        #1 eng_done = 1'b1;
        @(posedge iclk);
        #1 eng_done = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge iclk);
      if (ostart_work) since_start = 0;
      else since_start++;

      if (ostart_work) begin
        checks++;
        if (rd_idx == wr_idx) begin
          errors++;
          $display("FAIL start_unexpected: got ptr %0d addr %0d, no start expected", odata_start_ptr, owr_addr);
        end else begin
          if (int'(odata_start_ptr) != exp_ptr[rd_idx] || int'(owr_addr) != exp_addr[rd_idx] ||
              ihold || !oframe_busy) begin
            errors++;
            $display("FAIL start_tile%0d: got ptr %0d addr %0d hold %0b busy %0b, expected ptr %0d addr %0d hold 0 busy 1",
                     rd_idx, odata_start_ptr, owr_addr, ihold, oframe_busy, exp_ptr[rd_idx], exp_addr[rd_idx]);
          end
          rd_idx++;
        end
      end

      if (oframe_done) begin
        checks++;
        if (done_seen >= exp_done || rd_idx != wr_idx || !oframe_busy) begin
          errors++;
          $display("FAIL frame_done: got done #%0d (starts %0d/%0d busy %0b), expected %0d dones after all starts",
                   done_seen + 1, rd_idx, wr_idx, oframe_busy, exp_done);
        end
        done_seen++;
      end

      if (ovr_pend || oframe_overrun) begin
        checks++;
        if (oframe_overrun !== ovr_pend) begin
          errors++;
          $display("FAIL overrun_timing: got %0b, expected %0b", oframe_overrun, ovr_pend);
        end
        if (oframe_overrun) ovr_seen++;
      end
      ovr_pend = iframe_ready && oframe_busy && irst;

      if (otimeout) begin
        checks++;
        if (since_start != TO_CYC || to_seen >= exp_to) begin
          errors++;
          $display("FAIL timeout: got pulse %0d cycles after start (#%0d), expected %0d cycles, %0d pulses",
                   since_start, to_seen + 1, TO_CYC, exp_to);
        end
        to_seen++;
      end

      if (req_n != req_ack) begin
        checks++;
        case (req_kind)
          0: if (ostart_work || odata_start_ptr != 0 || owr_addr != 0 || oframe_busy ||
                 oframe_done || oframe_overrun || otimeout) begin
               errors++;
               $display("FAIL idle_outputs: got start %0b ptr %0d addr %0d busy %0b done %0b ovr %0b to %0b, expected all 0",
                        ostart_work, odata_start_ptr, owr_addr, oframe_busy, oframe_done, oframe_overrun, otimeout);
             end
          1: if (ostart_work || !oframe_busy || oframe_done) begin
               errors++;
               $display("FAIL stalled: got start %0b busy %0b done %0b, expected 0 1 0",
                        ostart_work, oframe_busy, oframe_done);
             end
          default: if (!ostart_work) begin
               errors++;
               $display("FAIL hold_release: got start %0b, expected 1", ostart_work);
             end
        endcase
        req_ack = req_n;
      end

      if (end_req != 0) begin
        checks++;
        if (rd_idx != wr_idx || done_seen != exp_done || ovr_seen != exp_ovr || to_seen != exp_to) begin
          errors++;
          $display("FAIL totals: got starts %0d done %0d ovr %0d to %0d, expected %0d %0d %0d %0d",
                   rd_idx, done_seen, ovr_seen, to_seen, wr_idx, exp_done, exp_ovr, exp_to);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic request(input int kind);
    req_kind = kind;
    req_n++;
  endtask

  task automatic push_frame(input int n, input bit with_done);
    for (int i = 0; i < n; i++) begin
      exp_ptr[wr_idx]  = exp_tab[i];
      exp_addr[wr_idx] = i;
      wr_idx++;
    end
    if (with_done) exp_done++;
  endtask

  task automatic pulse_frame();
    iframe_ready = 1'b1;
    tick();
    iframe_ready = 1'b0;
  endtask

  task automatic wait_starts(input int n);
    int cnt = 0;
    for (int c = 0; c < 400 && cnt < n; c++) begin
      @(negedge iclk);
      if (ostart_work) cnt++;
    end
  endtask

  task automatic wait_done();
    for (int c = 0; c < 1000; c++) begin
      @(negedge iclk);
      if (oframe_done) break;
    end
    tick();
    request(0);
    tick();
  endtask

  // Stimulus
  initial begin
    repeat (3) tick();
    request(0);
    tick();
    irst = 1'b1;
    tick();

    // Plain frame
    push_frame(8, 1'b1);
    pulse_frame();
    wait_done();

    // Back-pressure after the third tile
    push_frame(8, 1'b1);
    pulse_frame();
    wait_starts(3);
    tick();
    ihold = 1'b1;
    for (int i = 0; i < 14; i++) begin
      request(1);
      tick();
    end
    ihold = 1'b0;
    request(2);
    wait_done();

    // Overrun during WAIT
    push_frame(8, 1'b1);
    pulse_frame();
    wait_starts(2);
    tick();
    tick();
    exp_ovr++;
    pulse_frame();
    wait_done();

    // Done pulse in IDLE is ignored
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    request(0);
    tick();
    request(0);
    tick();

    // Done pulse in the ISSUE cycle is ignored; FSM parks in WAIT
    eng_en = 0;
    push_frame(8, 1'b1);
    pulse_frame();
    wait_starts(1);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      request(1);
      tick();
    end
    eng_en = 1;
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    wait_done();

    // Reset while waiting on the fifth tile
    push_frame(5, 1'b0);
    pulse_frame();
    wait_starts(5);
    tick();
    irst = 1'b0;
    tick();
    irst = 1'b1;
    request(0);
    repeat (10) tick();

    // Restart after reset begins at pointer 0
    push_frame(8, 1'b1);
    pulse_frame();
    wait_done();

`ifdef IM_COMPRESSION_CTRL_TIMEOUT_EN
    eng_en = 0;
    exp_to += 8;
    push_frame(8, 1'b1);
    pulse_frame();
    wait_done();
    eng_en = 1;
`endif

    end_req = 1;
    repeat (5) @(posedge iclk);
    $display("FAIL monitor_end: summary not reached");
    $fatal(1);
  end

endmodule
